// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: serialises PHT init walks and buffered EX updates onto the single PHT write port
module bp_update_scheduler #(
  parameter int IDX_WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         upd_valid,
  input  logic [IDX_WIDTH-1:0]         upd_idx,
  input  logic                         upd_taken,
  output logic                         upd_ready,
  input  logic                         rd_active,
  input  logic                         clear,
  output logic                         tbl_we,
  output logic [IDX_WIDTH-1:0]         tbl_idx,
  output logic                         tbl_taken,
  output logic                         tbl_init,
  output logic                         init_busy,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [15:0]                  drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [IDX_WIDTH-1:0] init_idx_q, init_idx_d;
  logic [IDX_WIDTH:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0] drop_q, drop_d;
  logic run, full, empty, push, pop, drop;
  logic [IDX_WIDTH:0] head_e;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction
  assign run = (state_q == RUN);
  assign full = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign upd_ready = run && !full;
  assign push = upd_valid && upd_ready && !clear;
  assign pop = run && !empty && !rd_active && !clear;
  assign drop = upd_valid && !upd_ready && !clear;
  assign head_e = empty ? '0 : mem_q[head_q];
  assign init_busy = !run;
  assign tbl_init = !run;
  assign tbl_we = !run || pop;
  assign tbl_idx = run ? head_e[IDX_WIDTH:1] : init_idx_q;
  assign tbl_taken = run && head_e[0];
  assign pending = count_q;
  assign drop_count = drop_q;
  always_comb begin
    state_d = clear ? INIT : (!run && &init_idx_q) ? RUN : state_q;
    init_idx_d = (clear || run) ? '0 : init_idx_q + 1'b1;
    head_d = clear ? '0 : pop ? nxt(head_q) : head_q;
    tail_d = clear ? '0 : push ? nxt(tail_q) : tail_q;
    count_d = clear ? '0 : count_q + CW'(push) - CW'(pop);
    drop_d = (drop && !(&drop_q)) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      init_idx_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      init_idx_q <= init_idx_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= {upd_idx, upd_taken};
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: queue-based reference model plus scripted scenarios and random traffic
module tb_bp_update_scheduler;
  localparam int IW = 5;
  localparam int D = 4;
  localparam int N = 1 << IW;
  logic clk = 0, rst = 1;
  logic upd_valid = 0, upd_taken = 0, rd_active = 0, clear = 0;
  logic [IW-1:0] upd_idx = '0;
  logic upd_ready, tbl_we, tbl_taken, tbl_init, init_busy;
  logic [IW-1:0] tbl_idx;
  logic [$clog2(D+1)-1:0] pending;
  logic [15:0] drop_count;
  int vectors = 0, miscompares = 0;
  bit m_init = 1;
  int m_ii = 0, m_drops = 0;
  logic [IW:0] q[$];

  bp_update_scheduler #(.IDX_WIDTH(IW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .rd_active(rd_active), .clear(clear), .tbl_we(tbl_we),
    .tbl_idx(tbl_idx), .tbl_taken(tbl_taken), .tbl_init(tbl_init), .init_busy(init_busy),
    .pending(pending), .drop_count(drop_count));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input logic v, input int i, input logic t, input logic rd, input logic c, input logic r);
    upd_valid = v; upd_idx = IW'(i); upd_taken = t; rd_active = rd; clear = c; rst = r;
  endtask

  task automatic tick;
    int sz;
    bit acc, do_pop;
    #1;
    sz = q.size();
    vectors++;
    acc = !m_init && sz < D;
    do_pop = !m_init && sz > 0 && !rd_active && !clear;
    chk("init_busy", init_busy, m_init);
    chk("upd_ready", upd_ready, acc);
    chk("tbl_init", tbl_init, m_init);
    chk("tbl_we", tbl_we, m_init || do_pop);
    chk("tbl_idx", tbl_idx, m_init ? m_ii : (sz > 0 ? q[0][IW:1] : 0));
    chk("tbl_taken", tbl_taken, (!m_init && sz > 0) ? q[0][0] : 1'b0);
    chk("pending", pending, sz);
    chk("drop_count", drop_count, m_drops);
    @(posedge clk);
    if (rst) begin
      m_init = 1; m_ii = 0; m_drops = 0; q.delete();
    end else begin
      if (upd_valid && !acc && !clear && m_drops < 16'hFFFF) m_drops++;
      if (clear) begin
        m_init = 1; m_ii = 0; q.delete();
      end else if (m_init) begin
        m_ii++;
        if (m_ii == N) begin m_init = 0; m_ii = 0; end
      end else begin
        if (do_pop) void'(q.pop_front());
        if (upd_valid && acc) q.push_back({upd_idx, upd_taken});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin drive(0, 0, 0, 0, 0, 0); tick(); end
  endtask

  initial begin
    @(negedge clk);
    // reset and full init walk
    drive(0, 0, 0, 0, 0, 1); tick(); tick();
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("lit_init_idx", tbl_idx, k);
      chk("lit_init_we", {tbl_we, tbl_init, init_busy}, 3'b111);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("lit_run_entry", {init_busy, upd_ready, tbl_we}, 3'b010);
    tick();
    // single update
    drive(1, 7, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("lit_single_pend", pending, 1);
    chk("lit_single_wr", {tbl_we, tbl_idx, tbl_taken, tbl_init}, {1'b1, 5'd7, 1'b1, 1'b0});
    tick();
    #1 chk("lit_single_empty", pending, 0);
    // contention and drop
    for (int k = 1; k <= 5; k++) begin
      drive(1, k, k[0], 1, 0, 0); #1;
      chk("lit_cont_ready", upd_ready, k < 5);
      tick();
    end
    #1 chk("lit_drop1", drop_count, 1);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("lit_drain", {tbl_we, tbl_idx}, {1'b1, 5'(k)});
      tick();
    end
    #1 chk("lit_drain_done", {tbl_we, pending}, 4'b0000);
    // simultaneous push and pop with two queued
    drive(1, 10, 0, 1, 0, 0); tick();
    drive(1, 11, 1, 1, 0, 0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 20 + k, 1, 0, 0, 0); #1;
      chk("lit_pp_pend", pending, 2);
      chk("lit_pp_idx", tbl_idx, k == 0 ? 10 : k == 1 ? 11 : 18 + k);
      tick();
    end
    idle(3);
    // clear with backlog
    for (int k = 0; k < 3; k++) begin drive(1, 3 + k, 0, 1, 0, 0); tick(); end
    #1 chk("lit_clr_pend3", pending, 3);
    drive(0, 0, 0, 1, 1, 0); tick();
    #1 chk("lit_clr_after", {pending, init_busy}, 4'b0001);
    chk("lit_clr_drop", drop_count, 1);
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 0, 0, 0, 0); #1;
      chk("lit_clr_walk", {tbl_init, tbl_idx}, {1'b1, 5'(k)});
      tick();
    end
    // rst during INIT
    drive(0, 0, 0, 0, 1, 0); tick();
    idle(10);
    #1 chk("lit_rst_at10", tbl_idx, 10);
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk("lit_rst_restart", {tbl_idx, drop_count}, 21'd0);
    tick();
    // random traffic
    for (int k = 0; k < 4000; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, N - 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 299) == 0, $urandom_range(0, 999) == 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
